// File: rtl/fetch_queue_unit.sv
// Front end of the Tomasulo core: instruction memory, program counter and a
// small in-order instruction queue feeding dispatch over a valid/ready handshake.
`default_nettype none

module fetch_queue_unit #(
  parameter int INSTR_W    = 16,
  parameter int IMEM_DEPTH = 16,
  parameter int IQ_DEPTH   = 4,
  parameter int NUM_INSTR  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               imem_we,
  input  logic [3:0]         imem_waddr,
  input  logic [INSTR_W-1:0] imem_wdata,
  input  logic               start,
  input  logic               flush,
  input  logic [3:0]         flush_pc,
  output logic               dq_valid,
  input  logic               dq_ready,
  output logic [INSTR_W-1:0] dq_instr,
  output logic [3:0]         dq_opcode,
  output logic [1:0]         dq_fu,
  output logic [3:0]         dq_pc,
  output logic [2:0]         iq_count,
  output logic               fetch_done
);

  localparam int PTR_W = $clog2(IQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int FC_W  = $clog2(NUM_INSTR + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [3:0]         pc, pc_nxt;
  logic [FC_W-1:0]    fetched, fetched_nxt;
  logic [PTR_W-1:0]   head, tail;
  logic [CNT_W-1:0]   count, count_nxt;
  logic               push, pop;
  logic [INSTR_W-1:0] fetch_instr;
  logic [INSTR_W-1:0] head_instr_nxt;
  logic [3:0]         head_pc_nxt;

  logic [INSTR_W-1:0] imem    [IMEM_DEPTH];
  logic [INSTR_W-1:0] iq_instr[IQ_DEPTH];
  logic [3:0]         iq_pc   [IQ_DEPTH];

  assign fetch_instr = imem[pc];

  always_comb begin
    pop  = (count != '0) && dq_ready && !flush;
    push = !flush && (state == FETCH) &&
           ((count < CNT_W'(IQ_DEPTH)) || pop);

    state_nxt   = state;
    pc_nxt      = pc;
    fetched_nxt = fetched;
    if (flush) begin
      state_nxt = FETCH;
      pc_nxt    = flush_pc;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nxt   = FETCH;
            pc_nxt      = '0;
            fetched_nxt = '0;
          end
        end
        FETCH: begin
          if (push) begin
            pc_nxt = pc + 4'd1;
            // Saturating so a flush out of DONE cannot wrap the counter.
            if (fetched < FC_W'(NUM_INSTR)) fetched_nxt = fetched + FC_W'(1);
            if (fetched >= FC_W'(NUM_INSTR - 1)) state_nxt = DONE;
          end
        end
        DONE: begin
          if (start) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end

    if (flush) begin
      count_nxt = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_nxt = count + CNT_W'(1);
        2'b01:   count_nxt = count - CNT_W'(1);
        default: count_nxt = count;
      endcase
    end

    // The freshly fetched word bypasses storage when it becomes the new head.
    if ((count == '0) || ((count == CNT_W'(1)) && pop)) begin
      head_instr_nxt = fetch_instr;
      head_pc_nxt    = pc;
    end else if (pop) begin
      head_instr_nxt = iq_instr[head + PTR_W'(1)];
      head_pc_nxt    = iq_pc[head + PTR_W'(1)];
    end else begin
      head_instr_nxt = iq_instr[head];
      head_pc_nxt    = iq_pc[head];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= '0;
      fetched    <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      dq_instr   <= '0;
      dq_pc      <= '0;
      fetch_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      fetched    <= fetched_nxt;
      count      <= count_nxt;
      fetch_done <= (state == DONE) && (count == '0);
      if (flush) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (push) tail <= tail + PTR_W'(1);
        if (pop)  head <= head + PTR_W'(1);
      end
      if (count_nxt != '0) begin
        dq_instr <= head_instr_nxt;
        dq_pc    <= head_pc_nxt;
      end
    end
  end

  // Storage arrays are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (imem_we && (state == IDLE)) imem[imem_waddr] <= imem_wdata;
    if (push) begin
      iq_instr[tail] <= fetch_instr;
      iq_pc[tail]    <= pc;
    end
  end

  assign dq_valid  = (count != '0);
  assign iq_count  = count;
  assign dq_opcode = dq_instr[INSTR_W-1:INSTR_W-4];

  always_comb begin
    dq_fu = 2'd3;
    case (dq_opcode)
      4'd0, 4'd1: dq_fu = 2'd0;
      4'd2, 4'd3: dq_fu = 2'd1;
      4'd4, 4'd5: dq_fu = 2'd2;
      default:    dq_fu = 2'd3;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue_unit.sv
// +----------------------------------------------------------------------+
// | Module      : tb_fetch_queue_unit                                    |
// | Description : Directed self-checking bench for fetch_queue_unit.     |
// | Revision    : 1.1                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_fetch_queue_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_we = 1'b0;
    logic [3:0]  imem_waddr = '0;
    logic [15:0] imem_wdata = '0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  flush_pc = '0;
    logic        dq_valid;
    logic        dq_ready = 1'b0;
    logic [15:0] dq_instr;
    logic [3:0]  dq_opcode;
    logic [1:0]  dq_fu;
    logic [3:0]  dq_pc;
    logic [2:0]  iq_count;
    logic        fetch_done;

    int vectors = 0;
    int miscompares = 0;

    fetch_queue_unit dut (
        .clk(clk), .rst_n(rst_n), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .start(start), .flush(flush), .flush_pc(flush_pc),
        .dq_valid(dq_valid), .dq_ready(dq_ready), .dq_instr(dq_instr),
        .dq_opcode(dq_opcode), .dq_fu(dq_fu), .dq_pc(dq_pc), .iq_count(iq_count),
        .fetch_done(fetch_done)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; dq_ready = 1'b0; imem_we = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic write_mem(input logic [3:0] a, input logic [15:0] d);
        imem_we = 1'b1; imem_waddr = a; imem_wdata = d;
        step();
        imem_we = 1'b0;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (dq_valid !== 1'b0 || iq_count !== 3'd0 || dq_instr !== 16'h0 || dq_pc !== 4'd0 ||
            dq_opcode !== 4'd0 || dq_fu !== 2'd0 || fetch_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: got valid=%b cnt=%0d instr=%h pc=%0d op=%0d fu=%0d done=%b, expected all zero",
                     dq_valid, iq_count, dq_instr, dq_pc, dq_opcode, dq_fu, fetch_done);
        end
        do_reset();
    endtask

    task automatic test_fill_backpressure;
        logic [15:0] exp_i;
        do_reset();
        for (int i = 0; i < 16; i++) write_mem(4'(i), 16'h1123 + 16'(i));
        dq_ready = 1'b0;
        pulse_start();
        for (int k = 1; k <= 7; k++) begin
            step();
            vectors++;
            if (iq_count !== 3'((k > 4) ? 4 : k) || dq_valid !== 1'b1 || dq_instr !== 16'h1123 ||
                dq_pc !== 4'd0 || dq_fu !== 2'd0) begin
                miscompares++;
                $display("FAIL fill[%0d]: got cnt=%0d valid=%b instr=%h pc=%0d fu=%0d, expected cnt=%0d valid=1 instr=1123 pc=0 fu=0",
                         k, iq_count, dq_valid, dq_instr, dq_pc, dq_fu, (k > 4) ? 4 : k);
            end
        end
        for (int k = 1; k <= 6; k++) begin
            exp_i = 16'h1123 + 16'(k);
            dq_ready = 1'b1;
            step();
            dq_ready = 1'b0;
            vectors++;
            if (iq_count !== 3'd4 || dq_pc !== 4'(k) || dq_instr !== exp_i) begin
                miscompares++;
                $display("FAIL bp_accept[%0d]: got cnt=%0d pc=%0d instr=%h, expected cnt=4 pc=%0d instr=%h",
                         k, iq_count, dq_pc, dq_instr, k, exp_i);
            end
            step();
            vectors++;
            if (iq_count !== 3'd4 || dq_pc !== 4'(k) || dq_instr !== exp_i || dq_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL bp_stall[%0d]: got cnt=%0d pc=%0d instr=%h valid=%b, expected cnt=4 pc=%0d instr=%h valid=1",
                         k, iq_count, dq_pc, dq_instr, dq_valid, k, exp_i);
            end
        end
    endtask

    task automatic test_streaming;
        do_reset();
        dq_ready = 1'b1;
        pulse_start();
        for (int k = 1; k <= 16; k++) begin
            step();
            vectors++;
            if (dq_valid !== 1'b1 || iq_count !== 3'd1 || dq_pc !== 4'(k - 1) ||
                dq_instr !== 16'h1123 + 16'(k - 1) || fetch_done !== 1'b0) begin
                miscompares++;
                $display("FAIL stream[%0d]: got valid=%b cnt=%0d pc=%0d instr=%h done=%b, expected valid=1 cnt=1 pc=%0d instr=%h done=0",
                         k, dq_valid, iq_count, dq_pc, dq_instr, fetch_done, k - 1, 16'h1123 + 16'(k - 1));
            end
        end
        step();
        vectors++;
        if (dq_valid !== 1'b0 || iq_count !== 3'd0 || fetch_done !== 1'b0 || dq_pc !== 4'd15) begin
            miscompares++;
            $display("FAIL stream_drain: got valid=%b cnt=%0d done=%b pc=%0d, expected valid=0 cnt=0 done=0 pc=15",
                     dq_valid, iq_count, fetch_done, dq_pc);
        end
        step();
        vectors++;
        if (fetch_done !== 1'b1 || dq_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_done: got done=%b valid=%b, expected done=1 valid=0", fetch_done, dq_valid);
        end
        dq_ready = 1'b0;
    endtask

    task automatic test_decode;
        logic [1:0] exp_fu [8];
        exp_fu = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
        do_reset();
        for (int i = 0; i < 16; i++) write_mem(4'(i), {4'(i), 12'h0A5});
        dq_ready = 1'b1;
        pulse_start();
        for (int k = 0; k < 8; k++) begin
            step();
            vectors++;
            if (dq_fu !== exp_fu[k] || dq_opcode !== 4'(k) || dq_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL decode[%0d]: got fu=%0d op=%0d valid=%b, expected fu=%0d op=%0d valid=1",
                         k, dq_fu, dq_opcode, dq_valid, exp_fu[k], k);
            end
        end
        dq_ready = 1'b0;
    endtask

    task automatic test_flush;
        do_reset();
        for (int i = 0; i < 16; i++) write_mem(4'(i), 16'h1123 + 16'(i));
        dq_ready = 1'b0;
        flush = 1'b1; flush_pc = 4'd4;
        step();
        flush = 1'b0;
        vectors++;
        if (iq_count !== 3'd0 || dq_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_idle: got cnt=%0d valid=%b, expected cnt=0 valid=0", iq_count, dq_valid);
        end
        step(); step(); step();
        vectors++;
        if (iq_count !== 3'd3 || dq_pc !== 4'd4 || dq_instr !== 16'h1127) begin
            miscompares++;
            $display("FAIL flush_setup: got cnt=%0d pc=%0d instr=%h, expected cnt=3 pc=4 instr=1127",
                     iq_count, dq_pc, dq_instr);
        end
        flush = 1'b1; flush_pc = 4'd2; dq_ready = 1'b1;
        step();
        flush = 1'b0;
        vectors++;
        if (dq_valid !== 1'b0 || iq_count !== 3'd0) begin
            miscompares++;
            $display("FAIL flush_clear: got valid=%b cnt=%0d, expected valid=0 cnt=0", dq_valid, iq_count);
        end
        step();
        vectors++;
        if (dq_valid !== 1'b1 || dq_pc !== 4'd2 || dq_instr !== 16'h1125 || iq_count !== 3'd1) begin
            miscompares++;
            $display("FAIL flush_redirect: got valid=%b pc=%0d instr=%h cnt=%0d, expected valid=1 pc=2 instr=1125 cnt=1",
                     dq_valid, dq_pc, dq_instr, iq_count);
        end
        step();
        vectors++;
        if (dq_pc !== 4'd3 || dq_instr !== 16'h1126) begin
            miscompares++;
            $display("FAIL flush_next: got pc=%0d instr=%h, expected pc=3 instr=1126", dq_pc, dq_instr);
        end
        dq_ready = 1'b0;
    endtask

    task automatic test_reset_and_write;
        do_reset();
        dq_ready = 1'b0;
        pulse_start();
        step(); step();
        vectors++;
        if (iq_count !== 3'd2) begin
            miscompares++;
            $display("FAIL midrun_setup: got cnt=%0d, expected 2", iq_count);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (dq_valid !== 1'b0 || iq_count !== 3'd0 || dq_instr !== 16'h0 || fetch_done !== 1'b0) begin
            miscompares++;
            $display("FAIL midrun_reset: got valid=%b cnt=%0d instr=%h done=%b, expected 0 0 0000 0",
                     dq_valid, iq_count, dq_instr, fetch_done);
        end
        do_reset();
        pulse_start();
        imem_we = 1'b1; imem_waddr = 4'd0; imem_wdata = 16'hBEEF;
        step(); step(); step();
        imem_we = 1'b0;
        do_reset();
        pulse_start();
        step();
        vectors++;
        if (dq_instr !== 16'h1123 || dq_pc !== 4'd0 || dq_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL write_in_fetch: got instr=%h pc=%0d valid=%b, expected instr=1123 pc=0 valid=1",
                     dq_instr, dq_pc, dq_valid);
        end
    endtask

    initial begin
        test_reset();
        test_fill_backpressure();
        test_streaming();
        test_decode();
        test_flush();
        test_reset_and_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Front end of the Tomasulo core. Holds the 16-entry instruction memory and the program counter.
- Fetches in order into a 4-entry instruction queue and presents the queue head, partially decoded, to the dispatch stage.
- Dispatch allocates ROB and reservation-station entries. A dispatch-side stall back-pressures fetch through a valid/ready handshake.

Parameters:
- INSTR_W, 16, instruction width: opcode[15:12], rd/rs[11:8], rs1/rb[7:4], rs2/imm[3:0]
- IMEM_DEPTH, 16, instruction memory words; PC width is log2(IMEM_DEPTH)
- IQ_DEPTH, 4, instruction queue entries (power of two)
- NUM_INSTR, 16, number of instructions fetched after start (1..IMEM_DEPTH)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_we  in  1  instruction memory write enable; honoured only in IDLE
- imem_waddr  in  4  write address
- imem_wdata  in  INSTR_W  write data
- start  in  1  one-cycle pulse: begin fetching at PC 0
- flush  in  1  discard queue and redirect fetch
- flush_pc  in  4  redirect target
- dq_valid  out  1  queue head holds a valid instruction
- dq_ready  in  1  dispatch accepts the head this cycle
- dq_instr  out  INSTR_W  head instruction
- dq_opcode  out  4  head opcode
- dq_fu  out  2  unit class: 0 add/sub, 1 mul/div, 2 load/store, 3 illegal
- dq_pc  out  4  PC of the head instruction
- iq_count  out  3  current queue occupancy, 0..4
- fetch_done  out  1  all NUM_INSTR instructions fetched and queue empty

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, pc=0, fetched=0, queue head, tail and count = 0.
  - dq_valid=0, dq_instr=0, dq_opcode=0, dq_fu=0, dq_pc=0, iq_count=0, fetch_done=0.
  - Instruction memory contents are not reset.
- FSM states:
  - IDLE -> FETCH on start (pc=0, fetched=0).
  - FETCH -> DONE on the cycle the NUM_INSTR-th instruction is pushed.
  - DONE -> IDLE on start (restart). start in FETCH is ignored.
- Memory writes:
  - Synchronous, in IDLE only. Writes in FETCH or DONE are dropped.
  - Memory read is combinational at pc.
- Push rule:
  - In FETCH, push imem[pc] and pc when (count<IQ_DEPTH) or (count==IQ_DEPTH and pop this cycle).
  - On push: pc increments modulo 16 (15 wraps to 0) and fetched increments.
- Pop rule: pop = dq_valid && dq_ready.
- Push and pop in the same cycle:
  - Count is unchanged.
  - When count==1, the pushed entry becomes the head the next cycle with no bubble.
- Fetch-to-dispatch latency: an instruction pushed at edge N is visible on dq_* after edge N if the queue was empty.
- Head outputs:
  - dq_* reflect the head entry whenever count>0 and hold stable while dq_valid=1 and dq_ready=0.
  - When count==0, dq_valid=0 and the data outputs hold their last value.
- Decode of dq_fu:
  - opcode 0000/0001 -> 0; 0010/0011 -> 1; 0100/0101 -> 2; 0110-1111 -> 3.
  - Illegal instructions are still dispatched. Dispatch raises the exception.
- Flush:
  - Takes priority over push, pop and start.
  - Next cycle: count=0, dq_valid=0, pc=flush_pc, state=FETCH, fetched unchanged.
  - A pop in the flush cycle is not acknowledged.
  - Flush in IDLE or DONE also enters FETCH.
- fetch_done = (state==DONE) && (count==0), registered.
- Reset mid-operation aborts fetch. All state returns to the reset values above.
- Pointers are log2(IQ_DEPTH) bits and wrap naturally. Occupancy is tracked by a separate counter, so full and empty are unambiguous.

Test Plan:
- Reset and fill:
  - Load imem[0..15]=0x1123+i in IDLE, pulse start with dq_ready=0.
  - Queue fills to iq_count=4 after 4 cycles and pc holds at 4.
  - dq_instr=0x1123, dq_pc=0, dq_fu=0.
- Streaming:
  - dq_ready=1 continuously after start.
  - 16 instructions are dispatched in order with no bubbles after the first.
  - fetch_done=1 one cycle after the last pop; iq_count never exceeds 1 at steady state.
- Back-pressure at full:
  - With count=4, toggle dq_ready 1/0.
  - Each accepted cycle pushes one new entry, count stays 4, and the head is stable while dq_ready=0.
- Decode:
  - imem holds opcodes 0..7; expect dq_fu sequence 0,0,1,1,2,2,3,3.
- Flush:
  - At count=3 with pc=7, assert flush with flush_pc=2 and dq_ready=1.
  - Next cycle dq_valid=0 and iq_count=0. The following cycle dq_pc=2.
  - The flushed-cycle instruction is not dispatched.
- Reset and writes during operation:
  - rst_n low mid-FETCH gives immediate dq_valid=0 and iq_count=0.
  - An imem_we during FETCH leaves memory unchanged when re-read after a restart.
